// File: rtl/addsub_result_stage.sv
// addsub_result_stage
// Two-entry result buffer sitting behind a 4-bit add/sub unit. Each accepted
// operation is stored with its carry and its derived zero/negative/overflow
// flags. Entries come out in FIFO order with a valid/ready handshake. A sticky
// overflow flag and a modulo-256 operation counter sit alongside the buffer.

module addsub_result_stage (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       M,
   input  logic [3:0] S,
   input  logic       C,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_result,
   output logic       out_carry,
   output logic       out_zero,
   output logic       out_neg,
   output logic       out_ovf,
   output logic       ovf_sticky,
   input  logic       clr,
   output logic [7:0] op_count
);

   // One buffered operation: the result plus every flag, so all fields move together
   typedef struct packed {
      logic [3:0] result;
      logic       carry;
      logic       zero;
      logic       neg;
      logic       ovf;
   } entry_t;

   entry_t     buf_mem [2];
   entry_t     new_entry;
   entry_t     head_entry;
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] occupancy;
   logic [3:0] b_eff;
   logic       push;
   logic       pop;

   // Handshake is derived only from stored occupancy, so out_ready never reaches in_ready
   assign in_ready  = (occupancy < 2'd2);
   assign out_valid = (occupancy != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Build the entry to store; B is inverted in subtract mode to see what the adder saw
   always_comb begin
      b_eff            = B ^ {4{M}};
      new_entry        = '0;
      new_entry.result = S;
      new_entry.carry  = C;
      new_entry.zero   = (S == 4'b0000);
      new_entry.neg    = S[3];
      new_entry.ovf    = (A[3] == b_eff[3]) && (S[3] != A[3]);
   end

   // Storage and pointers; reset wipes the contents so the outputs read as zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr] <= new_entry;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Occupancy tracks pushes minus pops; a simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occupancy <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 2'd1;
            2'b01:   occupancy <= occupancy - 2'd1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign head_entry = buf_mem[rd_ptr];
   assign out_result = head_entry.result;
   assign out_carry  = head_entry.carry;
   assign out_zero   = head_entry.zero;
   assign out_neg    = head_entry.neg;
   assign out_ovf    = head_entry.ovf;

   // Statistics; clr wins over a same-cycle push but never disturbs the buffer itself
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count   <= 8'd0;
         ovf_sticky <= 1'b0;
      end else if (clr) begin
         op_count   <= 8'd0;
         ovf_sticky <= 1'b0;
      end else if (push) begin
         op_count <= op_count + 8'd1;
         if (new_entry.ovf) begin
            ovf_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage
// Drives the result stage with directed scenarios and random traffic, and
// compares every cycle against a queue-based reference model that works from
// signed integer arithmetic.

module tb_addsub_result_stage;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       M;
   logic [3:0] S;
   logic       C;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic       out_carry;
   logic       out_zero;
   logic       out_neg;
   logic       out_ovf;
   logic       ovf_sticky;
   logic       clr;
   logic [7:0] op_count;

   typedef struct {
      int result;
      int carry;
      int zero;
      int neg;
      int ovf;
   } model_entry_t;

   model_entry_t expQ[$];
   int modelCount;
   int modelSticky;
   int totalChecks;
   int badChecks;

   addsub_result_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .M          (M),
      .S          (S),
      .C          (C),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_ovf    (out_ovf),
      .ovf_sticky (ovf_sticky),
      .clr        (clr),
      .op_count   (op_count)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: count it and report any mismatch
   task automatic checkOutput(input string tag, input int got, input int expected);
      totalChecks++;
      if (got != expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, expected, $time);
      end
   endtask

   // Compare every visible output against the reference model state
   task automatic checkState();
      checkOutput("in_ready", int'(in_ready), int'(expQ.size() < 2));
      checkOutput("out_valid", int'(out_valid), int'(expQ.size() > 0));
      checkOutput("op_count", int'(op_count), modelCount);
      checkOutput("ovf_sticky", int'(ovf_sticky), modelSticky);
      if (expQ.size() > 0) begin
         checkOutput("out_result", int'(out_result), expQ[0].result);
         checkOutput("out_carry", int'(out_carry), expQ[0].carry);
         checkOutput("out_zero", int'(out_zero), expQ[0].zero);
         checkOutput("out_neg", int'(out_neg), expQ[0].neg);
         checkOutput("out_ovf", int'(out_ovf), expQ[0].ovf);
      end
   endtask

   // Present one cycle of inputs (S/C come from an ideal adder), advance the model, check
   task automatic applyStimulus(input int a, input int b, input int m, input int iv,
                                input int ordy, input int cl, input int rn);
      int bx;
      int sum;
      int sa;
      int sb;
      int r;
      bit doPush;
      bit doPop;
      model_entry_t e;
      bx  = (m != 0) ? 15 - b : b;
      sum = a + bx + m;
      A         = 4'(a);
      B         = 4'(b);
      M         = (m != 0);
      S         = 4'(sum % 16);
      C         = (sum >= 16);
      in_valid  = (iv != 0);
      out_ready = (ordy != 0);
      clr       = (cl != 0);
      rst_n     = (rn != 0);
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      r  = (m != 0) ? sa - sb : sa + sb;
      e.result = sum % 16;
      e.carry  = int'(sum >= 16);
      e.zero   = int'((sum % 16) == 0);
      e.neg    = int'((sum % 16) >= 8);
      e.ovf    = int'(r > 7 || r < -8);
      doPop  = (expQ.size() > 0) && (ordy != 0);
      doPush = (expQ.size() < 2) && (iv != 0);
      @(posedge clk);
      #1;
      if (rn == 0) begin
         expQ.delete();
         modelCount  = 0;
         modelSticky = 0;
      end else begin
         if (doPop) void'(expQ.pop_front());
         if (doPush) expQ.push_back(e);
         if (cl != 0) begin
            modelCount  = 0;
            modelSticky = 0;
         end else if (doPush) begin
            modelCount = (modelCount + 1) % 256;
            if (e.ovf != 0) modelSticky = 1;
         end
      end
      checkState();
   endtask

   // Directed scenarios followed by random traffic
   initial begin
      totalChecks = 0;
      badChecks   = 0;
      modelCount  = 0;
      modelSticky = 0;
      rst_n = 1'b0; A = '0; B = '0; M = 1'b0; S = '0; C = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_result", int'(out_result), 0);
      checkOutput("reset_zero", int'(out_zero), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);

      // 5 + 3 = 8 overflows into the sign bit
      applyStimulus(5, 3, 0, 1, 1, 0, 1);
      checkOutput("add_result", int'(out_result), 8);
      checkOutput("add_neg", int'(out_neg), 1);
      checkOutput("add_ovf", int'(out_ovf), 1);
      checkOutput("add_zero", int'(out_zero), 0);
      checkOutput("add_sticky", int'(ovf_sticky), 1);
      checkOutput("add_count", int'(op_count), 1);

      // 5 - 5 = 0 with no borrow
      applyStimulus(5, 5, 1, 1, 1, 0, 1);
      checkOutput("sub_zero", int'(out_zero), 1);
      checkOutput("sub_carry", int'(out_carry), 1);
      checkOutput("sub_ovf", int'(out_ovf), 0);
      checkOutput("sub_neg", int'(out_neg), 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 1);

      // Fill with results 1 and 2, hold off 3, then drain in order
      applyStimulus(1, 0, 0, 1, 0, 0, 1);
      applyStimulus(2, 0, 0, 1, 0, 0, 1);
      checkOutput("full_in_ready", int'(in_ready), 0);
      applyStimulus(3, 0, 0, 1, 0, 0, 1);
      checkOutput("held_head", int'(out_result), 1);
      applyStimulus(3, 0, 0, 1, 1, 0, 1);
      checkOutput("drain_head2", int'(out_result), 2);
      checkOutput("drain_ready", int'(in_ready), 1);
      applyStimulus(3, 0, 0, 1, 1, 0, 1);
      checkOutput("pushpop_head3", int'(out_result), 3);
      checkOutput("pushpop_valid", int'(out_valid), 1);
      checkOutput("pushpop_ready", int'(in_ready), 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 1);
      checkOutput("drained_valid", int'(out_valid), 0);

      // 256 pushes wrap the counter, then clr with a push
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(i % 16, (i / 16) % 16, i % 2, 1, 1, 0, 1);
      end
      checkOutput("wrap_count", int'(op_count), 0);
      applyStimulus(7, 1, 0, 1, 1, 1, 1);
      checkOutput("clr_count", int'(op_count), 0);
      checkOutput("clr_sticky", int'(ovf_sticky), 0);
      checkOutput("clr_entry_valid", int'(out_valid), 1);
      checkOutput("clr_entry_result", int'(out_result), 8);
      applyStimulus(0, 0, 0, 0, 1, 0, 1);

      // Reset while holding two entries
      applyStimulus(5, 3, 0, 1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1, 0, 0, 1);
      applyStimulus(2, 0, 0, 1, 0, 0, 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_count", int'(op_count), 0);
      checkOutput("rst_sticky", int'(ovf_sticky), 0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 19) == 0),
                       int'($urandom_range(0, 49) != 0));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
